rng_card_dealer: RTL and testbench

Consumer side of the card counter interface. Drives the counter's request line, samples its 8-bit card value on a deal request, and rejects out-of-range or already-dealt values. Keeps a per-deck dealt mask and returns each of the 52 cards exactly once per shuffle, with a valid/ready handshake toward the game controller.

---
 rtl/rng_card_dealer_if.sv | 24 ++
 rtl/rng_card_dealer.sv | 79 +++++++
 tb/tb_rng_card_dealer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rng_card_dealer_if.sv
// rng_card_dealer_if: deal/handshake bundle between the card dealer, its counter and the game controller
// slave  (dealer)    : in  shuffle_i, deal_req_i, next_card_i
//                      out req_card_state_o, ready_o, card_valid_o, card_o, cards_left_o, deck_empty_o, deal_err_o
// master (env/game)  : the mirror image
interface rng_card_dealer_if #(parameter int CW = 8);
  logic          shuffle_i;
  logic          deal_req_i;
  logic [CW-1:0] next_card_i;
  logic          req_card_state_o;
  logic          ready_o;
  logic          card_valid_o;
  logic [CW-1:0] card_o;
  logic [5:0]    cards_left_o;
  logic          deck_empty_o;
  logic          deal_err_o;
  modport slave (
    input  shuffle_i, deal_req_i, next_card_i,
    output req_card_state_o, ready_o, card_valid_o, card_o, cards_left_o, deck_empty_o, deal_err_o
  );
  modport master (
    output shuffle_i, deal_req_i, next_card_i,
    input  req_card_state_o, ready_o, card_valid_o, card_o, cards_left_o, deck_empty_o, deal_err_o
  );
endinterface

// File: rtl/rng_card_dealer.sv
// rng_card_dealer: deals each card of a DECK_SIZE deck exactly once per shuffle, sampling a free-running counter
// clk_cd_i : system clock, rising edge
// rst_cd_i : synchronous active-high reset
// bus      : rng_card_dealer_if slave (shuffle/deal request, counter value in; run request, handshake, card, status out)
module rng_card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int CW        = 8
) (
  input  logic              clk_cd_i,
  input  logic              rst_cd_i,
  rng_card_dealer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HUNT, EMPTY} state_t;
  state_t               state_q, state_d;
  logic [DECK_SIZE-1:0] mask_q, mask_d, sel;
  logic [5:0]           left_q, left_d;
  logic [CW-1:0]        card_q, card_d, c;
  logic                 valid_q, valid_d, err_q, err_d, req_q, req_d, in_range, hit;
  assign c        = bus.next_card_i;
  assign in_range = (c >= CW'(1)) && (c <= CW'(DECK_SIZE));
  // one-hot of the sampled card, zero when out of range so it can never hit
  assign sel      = in_range ? (DECK_SIZE'(1) << (c - CW'(1))) : '0;
  assign hit      = (state_q == HUNT) && |(sel & ~mask_q);
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    left_d  = left_q;
    card_d  = card_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:    state_d = bus.deal_req_i ? HUNT : IDLE;
      HUNT:    if (hit) begin
        card_d  = c;
        valid_d = 1'b1;
        mask_d  = mask_q | sel;
        left_d  = left_q - 6'd1;
        state_d = (left_q == 6'd1) ? EMPTY : IDLE;
      end
      EMPTY:   err_d = bus.deal_req_i;
      default: state_d = IDLE;
    endcase
    if (bus.shuffle_i) begin
      state_d = IDLE;
      mask_d  = '0;
      left_d  = 6'(DECK_SIZE);
      card_d  = card_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
    req_d = (state_d != EMPTY);
  end
  always_ff @(posedge clk_cd_i) begin
    if (rst_cd_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      left_q  <= 6'(DECK_SIZE);
      card_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end
  assign bus.req_card_state_o = req_q;
  assign bus.ready_o          = (state_q == IDLE);
  assign bus.card_valid_o     = valid_q;
  assign bus.card_o           = card_q;
  assign bus.cards_left_o     = left_q;
  assign bus.deck_empty_o     = (left_q == 6'd0);
  assign bus.deal_err_o       = err_q;
endmodule

// File: tb/tb_rng_card_dealer.sv
// tb_rng_card_dealer: directed self-checking bench for rng_card_dealer with a wrap-at-52 counter model
module tb_rng_card_dealer;
  logic       clk = 0;
  logic       rst = 1;
  logic       force_en = 1;
  logic [7:0] forced = 0;
  logic [7:0] cnt;
  int         errors = 0;
  int         checks = 0;
  rng_card_dealer_if #(.CW(8)) bus();
  rng_card_dealer #(.DECK_SIZE(52), .CW(8)) dut (.clk_cd_i(clk), .rst_cd_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst) cnt <= 8'd0;
    else if (bus.req_card_state_o) cnt <= (cnt == 8'd52) ? 8'd0 : cnt + 8'd1;
  assign bus.next_card_i = force_en ? forced : cnt;
  task automatic request();
    @(negedge clk) bus.deal_req_i = 1;
    @(negedge clk) bus.deal_req_i = 0;
  endtask
  task automatic test_reset();
    bus.shuffle_i = 0; bus.deal_req_i = 0; rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (bus.card_o !== 8'd0) begin errors++; $display("FAIL reset_card got %0d want 0", bus.card_o); end
    checks++; if (bus.cards_left_o !== 6'd52) begin errors++; $display("FAIL reset_left got %0d want 52", bus.cards_left_o); end
    checks++; if ({bus.card_valid_o, bus.deal_err_o, bus.req_card_state_o, bus.deck_empty_o} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus.card_valid_o, bus.deal_err_o, bus.req_card_state_o, bus.deck_empty_o}); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    rst = 0;
    @(negedge clk);
    checks++; if (bus.req_card_state_o !== 1'b1) begin errors++; $display("FAIL req_after_reset got %b want 1", bus.req_card_state_o); end
  endtask
  task automatic test_first_deal();
    force_en = 1; forced = 8'd5;
    request();
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", bus.ready_o); end
    checks++; if (bus.card_valid_o !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", bus.card_valid_o); end
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o} !== {1'b1, 8'd5}) begin errors++; $display("FAIL first_deal got v=%b c=%0d want v=1 c=5", bus.card_valid_o, bus.card_o); end
    checks++; if ({bus.cards_left_o, bus.ready_o} !== {6'd51, 1'b1}) begin errors++; $display("FAIL first_left got l=%0d r=%b want l=51 r=1", bus.cards_left_o, bus.ready_o); end
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o} !== {1'b0, 8'd5}) begin errors++; $display("FAIL valid_pulse got v=%b c=%0d want v=0 c=5", bus.card_valid_o, bus.card_o); end
  endtask
  task automatic test_misses();
    logic [7:0] seq [4];
    seq = '{8'd0, 8'd53, 8'd255, 8'd7};
    request();
    for (int i = 0; i < 4; i++) begin
      forced = seq[i];
      @(negedge clk);
      if (i < 3) begin
        checks++; if ({bus.card_valid_o, bus.cards_left_o, bus.ready_o} !== {1'b0, 6'd51, 1'b0}) begin errors++; $display("FAIL miss_%0d got v=%b l=%0d r=%b want v=0 l=51 r=0", seq[i], bus.card_valid_o, bus.cards_left_o, bus.ready_o); end
      end
    end
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd7, 6'd50}) begin errors++; $display("FAIL miss_then_7 got v=%b c=%0d l=%0d want v=1 c=7 l=50", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
  endtask
  task automatic test_reject();
    forced = 8'd9;
    request();
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd9, 6'd49}) begin errors++; $display("FAIL deal9 got v=%b c=%0d l=%0d want v=1 c=9 l=49", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
    request();
    for (int i = 0; i < 2; i++) begin
      forced = 8'd9;
      @(negedge clk);
      checks++; if (bus.card_valid_o !== 1'b0) begin errors++; $display("FAIL dup9_%0d got v=%b want 0", i, bus.card_valid_o); end
    end
    forced = 8'd10;
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd10, 6'd48}) begin errors++; $display("FAIL deal10 got v=%b c=%0d l=%0d want v=1 c=10 l=48", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
  endtask
  task automatic test_shuffle_mid_hunt();
    forced = 8'd0;
    request();
    @(negedge clk);
    forced = 8'd11; bus.shuffle_i = 1; bus.deal_req_i = 1;
    @(negedge clk);
    bus.shuffle_i = 0; bus.deal_req_i = 0;
    checks++; if ({bus.card_valid_o, bus.ready_o, bus.cards_left_o, bus.card_o} !== {1'b0, 1'b1, 6'd52, 8'd10}) begin errors++; $display("FAIL shuffle got v=%b r=%b l=%0d c=%0d want v=0 r=1 l=52 c=10", bus.card_valid_o, bus.ready_o, bus.cards_left_o, bus.card_o); end
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.ready_o} !== 2'b01) begin errors++; $display("FAIL shuffle_drop got v=%b r=%b want v=0 r=1", bus.card_valid_o, bus.ready_o); end
    forced = 8'd5;
    request();
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd5, 6'd51}) begin errors++; $display("FAIL redeal5 got v=%b c=%0d l=%0d want v=1 c=5 l=51", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
  endtask
  task automatic test_full_deck();
    bit seen [53];
    int lat;
    @(negedge clk) bus.shuffle_i = 1;
    @(negedge clk) bus.shuffle_i = 0;
    force_en = 0;
    for (int k = 0; k < 52; k++) begin
      request();
      lat = 1;
      while (!bus.card_valid_o && lat < 60) begin @(negedge clk); lat++; end
      checks++; if (!bus.card_valid_o || lat > 54) begin errors++; $display("FAIL deck_latency deal %0d got lat=%0d v=%b want lat<=54 v=1", k, lat, bus.card_valid_o); end
      checks++;
      if (bus.card_o < 8'd1 || bus.card_o > 8'd52 || seen[bus.card_o]) begin errors++; $display("FAIL deck_card deal %0d got %0d want fresh 1..52", k, bus.card_o); end
      else seen[bus.card_o] = 1;
    end
    for (int v = 1; v <= 52; v++) begin
      checks++; if (!seen[v]) begin errors++; $display("FAIL deck_missing got none want card %0d", v); end
    end
    @(negedge clk);
    checks++; if ({bus.deck_empty_o, bus.req_card_state_o, bus.ready_o, bus.cards_left_o} !== {3'b100, 6'd0}) begin errors++; $display("FAIL deck_empty got e=%b q=%b r=%b l=%0d want e=1 q=0 r=0 l=0", bus.deck_empty_o, bus.req_card_state_o, bus.ready_o, bus.cards_left_o); end
    request();
    checks++; if ({bus.deal_err_o, bus.card_valid_o, bus.cards_left_o} !== {2'b10, 6'd0}) begin errors++; $display("FAIL deal_err got e=%b v=%b l=%0d want e=1 v=0 l=0", bus.deal_err_o, bus.card_valid_o, bus.cards_left_o); end
    @(negedge clk);
    checks++; if (bus.deal_err_o !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", bus.deal_err_o); end
  endtask
  task automatic test_reset_mid_hunt();
    int lat;
    rst = 1;
    @(negedge clk) rst = 0;
    force_en = 0;
    for (int k = 0; k < 10; k++) begin
      request();
      lat = 1;
      while (!bus.card_valid_o && lat < 60) begin @(negedge clk); lat++; end
    end
    checks++; if (bus.cards_left_o !== 6'd42) begin errors++; $display("FAIL ten_deals got l=%0d want 42", bus.cards_left_o); end
    force_en = 1; forced = 8'd0;
    request();
    rst = 1;
    @(negedge clk);
    checks++; if ({bus.card_o, bus.cards_left_o, bus.req_card_state_o, bus.card_valid_o} !== {8'd0, 6'd52, 2'b00}) begin errors++; $display("FAIL reset_hunt got c=%0d l=%0d q=%b v=%b want c=0 l=52 q=0 v=0", bus.card_o, bus.cards_left_o, bus.req_card_state_o, bus.card_valid_o); end
    rst = 0;
    forced = 8'd3;
    request();
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd3, 6'd51}) begin errors++; $display("FAIL resume got v=%b c=%0d l=%0d want v=1 c=3 l=51", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
  endtask
  task automatic test_back_to_back();
    forced = 8'd20;
    @(negedge clk) bus.deal_req_i = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.ready_o} !== {1'b1, 8'd20, 1'b1}) begin errors++; $display("FAIL b2b_first got v=%b c=%0d r=%b want v=1 c=20 r=1", bus.card_valid_o, bus.card_o, bus.ready_o); end
    forced = 8'd21;
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.ready_o} !== 2'b00) begin errors++; $display("FAIL b2b_accept got v=%b r=%b want v=0 r=0", bus.card_valid_o, bus.ready_o); end
    bus.deal_req_i = 0;
    @(negedge clk);
    checks++; if ({bus.card_valid_o, bus.card_o, bus.cards_left_o} !== {1'b1, 8'd21, 6'd49}) begin errors++; $display("FAIL b2b_second got v=%b c=%0d l=%0d want v=1 c=21 l=49", bus.card_valid_o, bus.card_o, bus.cards_left_o); end
  endtask
  initial begin
    test_reset();
    test_first_deal();
    test_misses();
    test_reject();
    test_shuffle_mid_hunt();
    test_full_deck();
    test_reset_mid_hunt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
